// File: rtl/interp_pkg.sv
// Shared types for the polyphase interpolator: sequencer state encoding and
// a ceiling-log2 helper used to size counters and indices.
package interp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // Never returns less than 1 so that single-value counters still get a bit.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/tap_sequencer.sv
// Polyphase tap sequencer: writes each accepted sample into the bank, then
// walks phases x taps newest-first. Optional TAP_SEQ_PRIME_ZERO_EN zeroes never-written taps.
module tap_sequencer
  import interp_pkg::*;
#(
  parameter int addrWidth = 8,
  parameter int dataWidth = 18,
  parameter int numTaps   = 16,
  parameter int numPhases = 4
) (
  input  logic                                 Clk_i,
  input  logic                                 Rst_n_i,
  input  logic [dataWidth-1:0]                 Din_i,
  input  logic                                 DinValid_i,
  output logic                                 DinReady_o,
  output logic                                 Wr_o,
  output logic [addrWidth-1:0]                 AddrWr_o,
  output logic [dataWidth-1:0]                 WrData_o,
  output logic [addrWidth-1:0]                 Addr_o,
  input  logic [dataWidth-1:0]                 BankDout_i,
  output logic [dataWidth-1:0]                 TapData_o,
  output logic [clog2(numPhases*numTaps)-1:0]  TapIdx_o,
  output logic                                 TapValid_o,
  output logic                                 TapFirst_o,
  output logic                                 TapLast_o
);

  localparam int AW = addrWidth;
  localparam int KW = clog2(numTaps);
  localparam int PW = clog2(numPhases);
  localparam int IW = clog2(numPhases * numTaps);

  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [KW-1:0] ONE_K  = KW'(1);
  localparam logic [PW-1:0] ONE_P  = PW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(numTaps - 1);
  localparam logic [PW-1:0] P_LAST = PW'(numPhases - 1);
  localparam logic [IW-1:0] TAPS_I = IW'(numTaps);

  seq_state_e     state_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [KW-1:0]  k_q;
  logic [PW-1:0]  p_q;
  logic           tap_valid_q;
  logic           tap_first_q;
  logic           tap_last_q;
  logic           tap_zero_q;
  logic [IW-1:0]  tap_idx_q;

  logic           idle_s;
  logic           issue_s;
  logic           last_k_s;
  logic           last_p_s;
  logic           zero_s;
  logic [AW-1:0]  rd_off_s;
  logic [IW-1:0]  issue_idx_s;

  // Reset gates the handshake so nothing is written while Rst_n_i is low.
  assign idle_s      = Rst_n_i & (state_q == ST_IDLE);
  assign DinReady_o  = idle_s;
  assign Wr_o        = idle_s & DinValid_i;
  assign AddrWr_o    = wr_ptr_q;
  assign WrData_o    = Din_i;

  assign issue_s     = (state_q == ST_RUN);
  assign last_k_s    = (k_q == K_LAST);
  assign last_p_s    = (p_q == P_LAST);
  assign rd_off_s    = issue_s ? AW'(k_q) : {AW{1'b0}};
  assign Addr_o      = wr_ptr_q - ONE_A - rd_off_s;
  assign issue_idx_s = (IW'(p_q) * TAPS_I) + IW'(k_q);

  assign TapValid_o  = tap_valid_q;
  assign TapFirst_o  = tap_first_q;
  assign TapLast_o   = tap_last_q;
  assign TapIdx_o    = tap_idx_q;
  assign TapData_o   = (tap_valid_q && !tap_zero_q) ? BankDout_i : {dataWidth{1'b0}};

`ifdef TAP_SEQ_PRIME_ZERO_EN
  localparam int FW = clog2(numTaps + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(numTaps);
  localparam logic [FW-1:0] ONE_F    = FW'(1);

  logic [FW-1:0] fill_q;

  assign zero_s = (FW'(k_q) >= fill_q);

  // Fill count saturates once the delay line has been fully primed.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      fill_q <= {FW{1'b0}};
    end else if (Wr_o && (fill_q != FILL_MAX)) begin
      fill_q <= fill_q + ONE_F;
    end else begin
      fill_q <= fill_q;
    end
  end
`else
  assign zero_s = 1'b0;
`endif

  // Sequencer FSM; tap qualifiers are registered to line up with bank read latency.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      k_q         <= {KW{1'b0}};
      p_q         <= {PW{1'b0}};
      tap_valid_q <= 1'b0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
      tap_zero_q  <= 1'b0;
      tap_idx_q   <= {IW{1'b0}};
    end else begin
      tap_valid_q <= issue_s;
      tap_first_q <= issue_s & (k_q == {KW{1'b0}});
      tap_last_q  <= issue_s & last_k_s;
      tap_zero_q  <= issue_s & zero_s;
      tap_idx_q   <= issue_s ? issue_idx_s : {IW{1'b0}};
      case (state_q)
        ST_IDLE: begin
          if (DinValid_i) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= wr_ptr_q + ONE_A;
            k_q      <= {KW{1'b0}};
            p_q      <= {PW{1'b0}};
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (last_k_s) begin
            k_q <= {KW{1'b0}};
            if (last_p_s) begin
              p_q     <= {PW{1'b0}};
              state_q <= ST_DRAIN;
            end else begin
              p_q <= p_q + ONE_P;
            end
          end else begin
            k_q <= k_q + ONE_K;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
